// File: rtl/zext_accumulator_if.sv
// Valid/ready sample input and frame-result output bundle for zext_accumulator.
interface zext_accumulator_if #(
  parameter int unsigned INPUT_WIDTH  = 4,
  parameter int unsigned OUTPUT_WIDTH = 8
);
  logic                    In_Valid;
  logic                    In_Ready;
  logic [INPUT_WIDTH-1:0]  Data_In;
  logic                    Out_Valid;
  logic                    Out_Ready;
  logic [OUTPUT_WIDTH-1:0] Data_Out;
  logic                    Overflow;

  modport master (
    output In_Valid, Data_In, Out_Ready,
    input  In_Ready, Out_Valid, Data_Out, Overflow
  );

  modport slave (
    input  In_Valid, Data_In, Out_Ready,
    output In_Ready, Out_Valid, Data_Out, Overflow
  );
endinterface

// File: rtl/zext_accumulator.sv
// Sums COUNT zero-extended unsigned samples per frame and holds the result,
// with a sticky carry flag, until the downstream consumer takes it.
module zext_accumulator #(
  parameter int unsigned INPUT_WIDTH  = 4,
  parameter int unsigned OUTPUT_WIDTH = 8,
  parameter int unsigned COUNT        = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  zext_accumulator_if.slave  bus
);

  localparam int unsigned SUM_W = OUTPUT_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  generate
    if (OUTPUT_WIDTH < INPUT_WIDTH) begin : g_bad_width
      $error("zext_accumulator: OUTPUT_WIDTH must be >= INPUT_WIDTH");
    end
    if (COUNT < 1) begin : g_bad_count
      $error("zext_accumulator: COUNT must be >= 1");
    end
  endgenerate

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic [OUTPUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                    overflow_q, overflow_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic [SUM_W-1:0]        sum_c;
  logic                    in_hs_c;
  logic                    out_hs_c;
  logic                    carry_c;

  // One extra bit on the adder exposes the carry out of the frame accumulator.
  always_comb begin
    sum_c    = SUM_W'(acc_q) + SUM_W'(bus.Data_In);
    carry_c  = sum_c[OUTPUT_WIDTH];
    in_hs_c  = bus.In_Valid & in_ready_q;
    out_hs_c = out_valid_q & bus.Out_Ready;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_ACCUM: begin
        if (in_hs_c) begin
          acc_d = sum_c[OUTPUT_WIDTH-1:0];
          ovf_d = ovf_q | carry_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d     = ST_HOLD;
            data_out_d  = sum_c[OUTPUT_WIDTH-1:0];
            overflow_d  = ovf_q | carry_c;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // Input stays closed through the handshake cycle; next frame starts after.
        if (out_hs_c) begin
          state_d     = ST_ACCUM;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_ACCUM;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.In_Ready  = in_ready_q;
  assign bus.Out_Valid = out_valid_q;
  assign bus.Data_Out  = data_out_q;
  assign bus.Overflow  = overflow_q;

endmodule

// File: tb/tb_zext_accumulator.sv
// Drives three accumulators (COUNT = 4, 20, 1) with identical stimulus and
// compares each against a frame-level arithmetic reference model.
module tb_zext_accumulator;

  localparam int unsigned IW = 4;
  localparam int unsigned OW = 8;
  localparam int NDUT = 3;

  logic          clk;
  logic          rst_r;
  logic          vin_r;
  logic [IW-1:0] din_r;
  logic          ordy_r;

  int checks;
  int failures;

  zext_accumulator_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus0 ();
  zext_accumulator_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus1 ();
  zext_accumulator_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus2 ();

  zext_accumulator #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .COUNT(4))
    dut0 (.Clk(clk), .Reset(rst_r), .bus(bus0));
  zext_accumulator #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .COUNT(20))
    dut1 (.Clk(clk), .Reset(rst_r), .bus(bus1));
  zext_accumulator #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .COUNT(1))
    dut2 (.Clk(clk), .Reset(rst_r), .bus(bus2));

  assign bus0.In_Valid = vin_r;  assign bus0.Data_In = din_r;  assign bus0.Out_Ready = ordy_r;
  assign bus1.In_Valid = vin_r;  assign bus1.Data_In = din_r;  assign bus1.Out_Ready = ordy_r;
  assign bus2.In_Valid = vin_r;  assign bus2.Data_In = din_r;  assign bus2.Out_Ready = ordy_r;

  logic          ob_ir [NDUT];
  logic          ob_ov [NDUT];
  logic          ob_of [NDUT];
  logic [OW-1:0] ob_d  [NDUT];

  assign ob_ir[0] = bus0.In_Ready;  assign ob_ov[0] = bus0.Out_Valid;
  assign ob_of[0] = bus0.Overflow;  assign ob_d[0]  = bus0.Data_Out;
  assign ob_ir[1] = bus1.In_Ready;  assign ob_ov[1] = bus1.Out_Valid;
  assign ob_of[1] = bus1.Overflow;  assign ob_d[1]  = bus1.Data_Out;
  assign ob_ir[2] = bus2.In_Ready;  assign ob_ov[2] = bus2.Out_Valid;
  assign ob_of[2] = bus2.Overflow;  assign ob_d[2]  = bus2.Data_Out;

  // Reference model: per-DUT frame bookkeeping in plain integers.
  int frame_len [NDUT] = '{4, 20, 1};
  int n_samp    [NDUT];
  int total     [NDUT];
  bit holding   [NDUT];
  bit fresh     [NDUT];
  int exp_data  [NDUT];
  bit exp_ovf   [NDUT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update(input bit rst, input bit vin, input int din, input bit ordy);
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        n_samp[k] = 0; total[k] = 0; holding[k] = 1'b0;
        fresh[k] = 1'b1; exp_data[k] = 0; exp_ovf[k] = 1'b0;
      end else if (holding[k]) begin
        if (ordy) begin
          holding[k] = 1'b0; n_samp[k] = 0; total[k] = 0;
        end
      end else if (vin) begin
        total[k]  += din;
        n_samp[k] += 1;
        if (n_samp[k] == frame_len[k]) begin
          holding[k]  = 1'b1;
          fresh[k]    = 1'b0;
          exp_data[k] = total[k] % (1 << OW);
          exp_ovf[k]  = total[k] > ((1 << OW) - 1);
        end
      end
    end
  endtask

  task automatic model_check(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      assert (ob_ir[k] === !holding[k]) else begin
        failures++;
        $error("FAIL %s in_ready dut%0d: got %b want %b", tag, k, ob_ir[k], !holding[k]);
      end
      checks++;
      assert (ob_ov[k] === holding[k]) else begin
        failures++;
        $error("FAIL %s out_valid dut%0d: got %b want %b", tag, k, ob_ov[k], holding[k]);
      end
      if (holding[k] || fresh[k]) begin
        checks++;
        assert (ob_d[k] === OW'(exp_data[k])) else begin
          failures++;
          $error("FAIL %s data_out dut%0d: got %h want %h", tag, k, ob_d[k], OW'(exp_data[k]));
        end
        checks++;
        assert (ob_of[k] === exp_ovf[k]) else begin
          failures++;
          $error("FAIL %s overflow dut%0d: got %b want %b", tag, k, ob_of[k], exp_ovf[k]);
        end
      end
    end
  endtask

  // One clock: drive at negedge, advance model, check #1 after the rising edge.
  task automatic step(input bit rst, input bit vin, input int din, input bit ordy, input string tag);
    @(negedge clk);
    rst_r  = rst;
    vin_r  = vin;
    din_r  = IW'(din);
    ordy_r = ordy;
    model_update(rst, vin, din, ordy);
    @(posedge clk);
    #1;
    model_check(tag);
  endtask

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  initial begin
    int s29 [4] = '{0, 5, 15, 15};
    int g_v [7] = '{1, 0, 0, 1, 0, 1, 1};
    int g_d [7] = '{3, 0, 0, 4, 0, 2, 1};
    checks = 0; failures = 0;
    rst_r = 1'b1; vin_r = 1'b0; din_r = '0; ordy_r = 1'b0;

    step(1, 0, 0, 0, "reset");
    step(1, 1, 9, 1, "reset_hs");
    chk("reset_data", ob_d[0], 8'h00);
    chk("reset_in_ready", OW'(ob_ir[0]), 8'h01);

    // Back-to-back 0,5,15,15.
    for (int i = 0; i < 4; i++) step(0, 1, s29[i], 1, "b2b");
    chk("b2b_valid", OW'(ob_ov[0]), 8'h01);
    chk("b2b_data", ob_d[0], 8'h23);
    chk("b2b_ovf", OW'(ob_of[0]), 8'h00);
    step(0, 0, 0, 1, "b2b_out");
    chk("b2b_back_accum", OW'(ob_ir[0]), 8'h01);

    // Long frame overflow, then a short clean frame.
    step(1, 0, 0, 0, "rst30");
    for (int i = 0; i < 20; i++) step(0, 1, 15, 0, "f20");
    chk("f20_valid", OW'(ob_ov[1]), 8'h01);
    chk("f20_data", ob_d[1], 8'h2C);
    chk("f20_ovf", OW'(ob_of[1]), 8'h01);
    step(0, 0, 0, 1, "f20_out");
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, "ones");
    chk("ones_data", ob_d[0], 8'h04);
    chk("ones_ovf", OW'(ob_of[0]), 8'h00);
    step(0, 0, 0, 1, "ones_out");

    // Backpressure while valid input keeps arriving.
    step(1, 0, 0, 0, "rst31");
    for (int i = 0; i < 4; i++) step(0, 1, 2, 0, "bp_fill");
    for (int i = 0; i < 3; i++) step(0, 1, 9, 0, "bp_stall");
    chk("bp_in_ready", OW'(ob_ir[0]), 8'h00);
    chk("bp_data", ob_d[0], 8'h08);
    step(0, 1, 9, 1, "bp_release");
    chk("bp_release_ready", OW'(ob_ir[0]), 8'h01);
    for (int i = 0; i < 4; i++) step(0, 1, 3, 0, "bp_next");
    chk("bp_next_data", ob_d[0], 8'h0C);

    // Gaps between samples.
    step(1, 0, 0, 0, "rst32");
    for (int i = 0; i < 7; i++) begin
      step(0, g_v[i] != 0, g_d[i], 0, "gaps");
      if (i == 5) chk("gaps_not_yet", OW'(ob_ov[0]), 8'h00);
    end
    chk("gaps_data", ob_d[0], 8'h0A);

    // Reset discards a partial frame.
    step(1, 0, 0, 0, "rst33");
    step(0, 1, 7, 0, "part");
    step(0, 1, 7, 0, "part");
    step(1, 1, 7, 0, "mid_rst");
    chk("mid_rst_valid", OW'(ob_ov[0]), 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, "after_rst");
    chk("after_rst_data", ob_d[0], 8'h04);

    // Reset wins over an output handshake in HOLD.
    step(1, 0, 0, 0, "rst34");
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, "hold_fill");
    step(1, 0, 0, 1, "hold_rst");
    chk("hold_rst_valid", OW'(ob_ov[0]), 8'h00);
    chk("hold_rst_data", ob_d[0], 8'h00);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 15)), $urandom_range(0, 2) != 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
